// File: rtl/num2char_sched.sv
// Four-channel round-robin front end for a single num2char converter: grants one
// requester, captures 10 ASCII digits, and streams a "<id>:<digits>\r\n" frame.
// Optional LEAD_ZERO_BLANK_EN: leading '0' digits (except the last) are sent as spaces.
module num2char_sched #(
  parameter int TIMEOUT = 64
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [3:0]   i_req,
  input  logic [127:0] i_val,
  output logic [3:0]   o_gnt,
  output logic         o_conv_start,
  output logic [31:0]  o_conv_value,
  input  logic [7:0]   i_conv_char,
  input  logic         i_conv_valid,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_valid,
  input  logic         i_tx_ready,
  output logic         o_busy,
  output logic         o_err_timeout
);

  localparam int NDIG = 10;
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_END  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DIG,
    SEND
  } state_t;

  state_t      r_state;
  logic [1:0]  r_lastGrant;
  logic [1:0]  r_chan;
  logic [3:0]  r_dcnt;
  logic [TW-1:0] r_timer;
  logic [3:0]  r_bi;
  logic [3:0]  r_gnt;
  logic        r_convStart;
  logic [31:0] r_convValue;
  logic [7:0]  r_txData;
  logic        r_txValid;
  logic        r_busy;
  logic        r_errTimeout;
  logic [7:0]  r_buf [NDIG];

  state_t      w_state;
  logic [1:0]  w_lastGrant;
  logic [1:0]  w_chan;
  logic [3:0]  w_dcnt;
  logic [TW-1:0] w_timer;
  logic [3:0]  w_bi;
  logic [3:0]  w_gnt;
  logic        w_convStart;
  logic [31:0] w_convValue;
  logic [7:0]  w_txData;
  logic        w_txValid;
  logic        w_busy;
  logic        w_errTimeout;
  logic        w_shift;

  logic        w_found;
  logic [1:0]  w_pick;
  logic [1:0]  w_cand;
  logic [7:0]  w_digit [NDIG];
  logic [3:0]  w_nbi;
  logic [7:0]  w_nextByte;
`ifdef LEAD_ZERO_BLANK_EN
  logic        w_leading;
`endif

  // Search starts one past the last winner so every channel gets a turn.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_lastGrant;
    w_cand  = '0;
    for (int k = 1; k <= 4; k++) begin
      w_cand = r_lastGrant + 2'(k);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
`ifdef LEAD_ZERO_BLANK_EN
    w_leading = 1'b1;
`endif
    for (int j = 0; j < NDIG; j++) begin
      w_digit[j] = r_buf[j];
`ifdef LEAD_ZERO_BLANK_EN
      if (j < NDIG - 1 && w_leading && r_buf[j] == 8'h30) begin
        w_digit[j] = 8'h20;
      end else begin
        w_leading = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    w_nbi      = r_bi + 4'd1;
    w_nextByte = 8'h00;
    if (w_nbi == 4'd1) begin
      w_nextByte = 8'h3A;
    end else if (w_nbi >= 4'd2 && w_nbi <= 4'd11) begin
      w_nextByte = w_digit[w_nbi - 4'd2];
    end else if (w_nbi == 4'd12) begin
      w_nextByte = 8'h0D;
    end else if (w_nbi == 4'd13) begin
      w_nextByte = 8'h0A;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_lastGrant  = r_lastGrant;
    w_chan       = r_chan;
    w_dcnt       = r_dcnt;
    w_timer      = r_timer;
    w_bi         = r_bi;
    w_gnt        = '0;
    w_convStart  = 1'b0;
    w_convValue  = r_convValue;
    w_txData     = r_txData;
    w_txValid    = r_txValid;
    w_errTimeout = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state     = START;
          w_gnt       = 4'b0001 << w_pick;
          w_convValue = i_val[{w_pick, 5'd0} +: 32];
          w_chan      = w_pick;
          w_lastGrant = w_pick;
        end
      end
      START: begin
        w_convStart = 1'b1;
        w_dcnt      = '0;
        w_timer     = '0;
        w_state     = WAIT_DIG;
      end
      WAIT_DIG: begin
        // The pulse cycle itself stays busy; the record is dropped on its way out.
        if (r_timer == TIMER_END) begin
          w_state = IDLE;
        end else begin
          w_timer = r_timer + 1'b1;
          if (r_timer == TIMER_LAST) begin
            w_errTimeout = 1'b1;
          end
          if (i_conv_valid) begin
            w_shift = 1'b1;
            w_dcnt  = r_dcnt + 4'd1;
            if (r_dcnt == 4'(NDIG - 1)) begin
              w_state      = SEND;
              w_errTimeout = 1'b0;
              w_bi         = '0;
              w_txValid    = 1'b1;
              w_txData     = {6'b001100, r_chan};
            end
          end
        end
      end
      SEND: begin
        if (r_txValid && i_tx_ready) begin
          if (r_bi == 4'd13) begin
            w_txValid = 1'b0;
            w_state   = IDLE;
          end else begin
            w_bi     = w_nbi;
            w_txData = w_nextByte;
          end
        end
      end
      default: w_state = IDLE;
    endcase
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_lastGrant  <= 2'd3;
      r_chan       <= '0;
      r_dcnt       <= '0;
      r_timer      <= '0;
      r_bi         <= '0;
      r_gnt        <= '0;
      r_convStart  <= 1'b0;
      r_convValue  <= '0;
      r_txData     <= '0;
      r_txValid    <= 1'b0;
      r_busy       <= 1'b0;
      r_errTimeout <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_lastGrant  <= w_lastGrant;
      r_chan       <= w_chan;
      r_dcnt       <= w_dcnt;
      r_timer      <= w_timer;
      r_bi         <= w_bi;
      r_gnt        <= w_gnt;
      r_convStart  <= w_convStart;
      r_convValue  <= w_convValue;
      r_txData     <= w_txData;
      r_txValid    <= w_txValid;
      r_busy       <= w_busy;
      r_errTimeout <= w_errTimeout;
    end
  end

  // Digits shift in from the top, so after ten beats r_buf[0] holds the MSD.
  always_ff @(posedge i_clk) begin
    if (w_shift) begin
      for (int j = 0; j < NDIG - 1; j++) begin
        r_buf[j] <= r_buf[j+1];
      end
      r_buf[NDIG-1] <= i_conv_char;
    end
  end

  assign o_gnt         = r_gnt;
  assign o_conv_start  = r_convStart;
  assign o_conv_value  = r_convValue;
  assign o_tx_data     = r_txData;
  assign o_tx_valid    = r_txValid;
  assign o_busy        = r_busy;
  assign o_err_timeout = r_errTimeout;

endmodule

// File: doc/num2char_sched.md
# num2char_sched

Round-robin scheduler that shares one num2char binary-to-ASCII converter among four 32-bit value requesters. It arbitrates requests, launches a conversion and captures the converter's 10 unhandshaked digit beats into a local buffer. It then emits a framed ASCII record (channel id, ':', 10 digits, CR, LF) on a valid/ready byte stream toward the UART/display path. It sits between the receiver status sources (error rate, level, etc.) and num2char.

## Interface
- TIMEOUT, 64: cycles allowed from conv_start to the 10th captured digit.
- NDIG, 10: digits per conversion; fixed to the converter's 40-bit BCD width.

- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  reset. Asynchronous and active-low.
- req  in  4  level request per channel; held until the matching gnt.
- val  in  128  channel values, channel i at val[32*i+31:32*i]; stable while req[i] is high.
- gnt  out  4  one-cycle pulse; value of that channel latched.
- conv_start  out  1  one-cycle start pulse to converter start_update.
- conv_value  out  32  latched value to converter error_rate; held until next grant.
- conv_char  in  8  converter char output.
- conv_valid  in  1  converter valid_o; one digit per high cycle, MSD first.
- tx_data  out  8  frame byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts on tx_valid && tx_ready.
- busy  out  1  high whenever state != IDLE.
- err_timeout  out  1  one-cycle pulse on conversion timeout.

## Operation
- States: IDLE, START, WAIT_DIG, SEND, then back to IDLE.
- IDLE: if any req bit is set, select the first set bit searching from (last_grant+1) mod 4.
  - Latch val of that channel into conv_value and its id into chan.
  - Pulse gnt[id]; go to START. last_grant resets to 3, so channel 0 wins first.
- START: conv_start=1 for this cycle; clear the digit count and timer; go to WAIT_DIG.
- WAIT_DIG: each cycle with conv_valid=1 writes conv_char into buf[dcnt] and increments dcnt.
  - When dcnt reaches 10, go to SEND. conv_valid beats beyond the 10th are ignored.
  - The timer increments every cycle. If it reaches TIMEOUT before dcnt=10, pulse err_timeout, drop the record, return to IDLE.
  - conv_valid outside WAIT_DIG is ignored.
- SEND: byte index bi runs 0..13 and emits '0'+chan, ':', buf[0..9], 0x0D, 0x0A.
  - bi advances only on tx_valid && tx_ready. After byte 13 is accepted, go to IDLE.
- Requests arriving during busy are held by the requester and are not lost. They are arbitrated in the first IDLE cycle.
- Reset mid-operation: abort immediately to IDLE. Buffer contents are don't-care. Any partial frame is abandoned without CR/LF.

## Timing
- Reset values: gnt=0, conv_start=0, conv_value=0, tx_data=0, tx_valid=0, busy=0, err_timeout=0, last_grant=3.
- All outputs are registered.
- Cycle accounting:
  - IDLE with req at cycle t: gnt and busy at t+1 (START state registered).
  - conv_start at t+2.
  - Converter digits nominally arrive at conv_start+35..+44.
- tx_valid rises the cycle after the 10th digit is captured.
- tx_data/tx_valid are held stable while tx_ready=0. With tx_ready tied high, a frame takes 14 consecutive cycles.
- err_timeout asserts exactly TIMEOUT cycles after conv_start when fewer than 10 digits have arrived.
- busy falls the cycle after the LF transfer or the timeout pulse. The next gnt can occur one cycle after that.

## Configuration
- LEAD_ZERO_BLANK_EN defined:
  - In SEND, every '0' digit before the first nonzero digit is replaced with 0x20 (space).
  - buf[9] is never blanked, so value 0 shows as nine spaces then '0'.
  - Frame length is unchanged (14 bytes).
- LEAD_ZERO_BLANK_EN undefined: digits are sent exactly as captured.

## Test plan
- req=0001, val0=12345, tx_ready=1 -> one gnt[0] pulse, conv_value=0x3039; tx bytes "0:0000012345" 0x0D 0x0A, then busy=0.
- req=0101 asserted together and held -> channel 0 framed first, then channel 2 (gnt[2] after first LF). With req0 held again afterwards, the next grant is 0.
- val3=0xFFFFFFFF on req[3] -> frame "3:4294967295\r\n".
- tx_ready toggled 1,0,0,1,... -> tx_data never changes while tx_valid=1 and tx_ready=0; all 14 bytes are delivered exactly once and in order.
- Converter model suppresses conv_valid after 4 digits -> err_timeout pulses 64 cycles after conv_start, no tx_valid, IDLE next cycle. A subsequent request then completes normally.
- LEAD_ZERO_BLANK_EN defined, val1=0 -> "1:" + nine 0x20 + '0' + CR LF. With val1=7000000000 mod 2^32, only the leading zeros are blanked.
